// File: rtl/iic_eeprom_ctrl.sv
// Single-byte random write/read master for a 24C02-class IIC EEPROM.
// The bus is paced by quarter-bit ticks taken from rising edges of the
// divider square wave sclk_in. SCL is push-pull; SDA is open-drain (0 or Z).
`timescale 1ns/1ps
module iic_eeprom_ctrl #(
   parameter logic [6:0] DEV_ADDR = 7'b1010000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk_in,
   input  logic       start,
   input  logic       rw,
   input  logic [7:0] word_addr,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       scl,
   inout  wire        sda
);

   typedef enum logic [3:0] {
      IDLE, START, DEVW, ACK1, WADDR, ACK2, WDATA, ACK3,
      RSTART, DEVR, ACK4, RDBYTE, MNACK, STOP, FINISH
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] q, q_nxt;
   logic [2:0] bit_cnt, bit_nxt;
   logic       rw_r, rw_nxt;
   logic [7:0] addr_r, addr_nxt;
   logic [7:0] data_r, data_nxt;
   logic [7:0] rx_sh, rx_nxt;
   logic [7:0] rd_nxt;
   logic       err_nxt;
   logic       scl_nxt;
   logic       sda_low, sda_low_nxt;
   logic       sync1, sync2, sync3;
   logic       tick;
   logic       sda_m, sda_s;
   logic [7:0] tx_byte;
   logic       tx_bit;
   logic       slot_start, slot_out, slot_ack;

   assign sda  = sda_low ? 1'b0 : 1'bz;
   assign tick = sync2 & ~sync3;
   assign busy = (state != IDLE) && (state != FINISH);
   assign done = (state == FINISH);

   // synchronise sclk_in (third stage only for edge detect) and the SDA input
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
         sda_m <= 1'b1;
         sda_s <= 1'b1;
      end else begin
         sync1 <= sclk_in;
         sync2 <= sync1;
         sync3 <= sync2;
         sda_m <= sda;
         sda_s <= sda_m;
      end
   end

   // classify the current slot and select the byte being shifted out
   always_comb begin
      tx_byte = '0;
      case (state)
         DEVW:    tx_byte = {DEV_ADDR, 1'b0};
         DEVR:    tx_byte = {DEV_ADDR, 1'b1};
         WADDR:   tx_byte = addr_r;
         WDATA:   tx_byte = data_r;
         default: tx_byte = '0;
      endcase
      tx_bit     = tx_byte[3'd7 - bit_cnt];
      slot_start = (state == START) || (state == RSTART);
      slot_out   = (state == DEVW) || (state == WADDR) || (state == WDATA) || (state == DEVR);
      slot_ack   = (state == ACK1) || (state == ACK2) || (state == ACK3) || (state == ACK4);
   end

   // FSM and bus-driver state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         q       <= '0;
         bit_cnt <= '0;
         rw_r    <= 1'b0;
         addr_r  <= '0;
         data_r  <= '0;
         rx_sh   <= '0;
         rd_data <= '0;
         ack_err <= 1'b0;
         scl     <= 1'b1;
         sda_low <= 1'b0;
      end else begin
         state   <= state_nxt;
         q       <= q_nxt;
         bit_cnt <= bit_nxt;
         rw_r    <= rw_nxt;
         addr_r  <= addr_nxt;
         data_r  <= data_nxt;
         rx_sh   <= rx_nxt;
         rd_data <= rd_nxt;
         ack_err <= err_nxt;
         scl     <= scl_nxt;
         sda_low <= sda_low_nxt;
      end
   end

   // next-state: accept requests, then walk each slot through its four quarters
   always_comb begin
      state_nxt   = state;
      q_nxt       = q;
      bit_nxt     = bit_cnt;
      rw_nxt      = rw_r;
      addr_nxt    = addr_r;
      data_nxt    = data_r;
      rx_nxt      = rx_sh;
      rd_nxt      = rd_data;
      err_nxt     = ack_err;
      scl_nxt     = scl;
      sda_low_nxt = sda_low;

      case (state)
         IDLE, FINISH: begin
            // the done cycle already has busy low, so a start there is taken directly
            if (state == FINISH) state_nxt = IDLE;
            if (start) begin
               state_nxt = START;
               q_nxt     = '0;
               bit_nxt   = '0;
               rw_nxt    = rw;
               addr_nxt  = word_addr;
               data_nxt  = wr_data;
               err_nxt   = 1'b0;
            end
         end
         default: begin
            if (tick) begin
               q_nxt = q + 2'd1;
               case (q)
                  2'd0: begin
                     if (slot_out) begin
                        sda_low_nxt = ~tx_bit;
                        scl_nxt     = 1'b0;
                     end else if (state == STOP) begin
                        sda_low_nxt = 1'b1;
                     end else begin
                        sda_low_nxt = 1'b0;
                     end
                     if (state == MNACK) rd_nxt = rx_sh;
                  end
                  2'd1: scl_nxt = 1'b1;
                  2'd2: begin
                     if (slot_start) begin
                        sda_low_nxt = 1'b1;
                     end else if (state == STOP) begin
                        sda_low_nxt = 1'b0;
                     end else if (slot_ack) begin
                        if (sda_s) err_nxt = 1'b1;
                     end else if (state == RDBYTE) begin
                        rx_nxt = {rx_sh[6:0], sda_s};
                     end
                  end
                  2'd3: begin
                     if (state != STOP) scl_nxt = 1'b0;
                     case (state)
                        START:  state_nxt = DEVW;
                        RSTART: state_nxt = DEVR;
                        DEVW, WADDR, WDATA, DEVR, RDBYTE: begin
                           bit_nxt = bit_cnt + 3'd1;
                           if (bit_cnt == 3'd7) begin
                              case (state)
                                 DEVW:    state_nxt = ACK1;
                                 WADDR:   state_nxt = ACK2;
                                 WDATA:   state_nxt = ACK3;
                                 DEVR:    state_nxt = ACK4;
                                 default: state_nxt = MNACK;
                              endcase
                           end
                        end
                        ACK1:    state_nxt = ack_err ? STOP : WADDR;
                        ACK2:    state_nxt = ack_err ? STOP : (rw_r ? RSTART : WDATA);
                        ACK3:    state_nxt = STOP;
                        ACK4:    state_nxt = ack_err ? STOP : RDBYTE;
                        MNACK:   state_nxt = STOP;
                        STOP:    state_nxt = FINISH;
                        default: state_nxt = IDLE;
                     endcase
                  end
                  default: q_nxt = '0;
               endcase
            end
         end
      endcase
   end

endmodule

// File: tb/tb_iic_eeprom_ctrl.sv
// Self-checking bench for iic_eeprom_ctrl: directed table, hand sequences for
// reset and clock-freeze corners, and randomized transactions against a
// transaction-level reference model with an open-drain EEPROM slave.
`timescale 1ns/1ps
module tb_iic_eeprom_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sclk_in = 1'b0;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [7:0] word_addr = '0;
   logic [7:0] wr_data = '0;
   logic [7:0] rd_data;
   logic       busy, done, ack_err, scl;
   wire        sda;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int div_cnt = 0;
   logic hold = 1'b0;

   // slave / bus monitor state
   logic       slave_low = 1'b0;
   logic       slave_nack = 1'b0;
   logic       tx_mode = 1'b0;
   logic       pending_tx = 1'b0;
   logic       ack_drv;
   int         bitn = 0;
   int         byte_idx = 0;
   logic [7:0] shreg = '0;
   logic [7:0] ptr = '0;
   logic [7:0] txbyte = '0;
   logic [7:0] mem [256];
   logic       p_scl = 1'b1, p_sda = 1'b1, c_scl, c_sda;
   int         bus_log[$];

   // reference model state
   logic [7:0] mem_ref [256];
   logic [7:0] rd_ref = '0;

   typedef struct {
      logic       v_rw;
      logic [7:0] v_addr;
      logic [7:0] v_data;
      logic       v_nack;
      int         v_glitch;
      logic [7:0] e_rd;
      logic       e_err;
      int         e_ticks;
   } vec_t;
   vec_t vecs[6];

   assign sda = slave_low ? 1'b0 : 1'bz;
   pullup (sda);

   iic_eeprom_ctrl #(.DEV_ADDR(7'b1010000)) dut (
      .clk(clk), .rst(rst), .sclk_in(sclk_in), .start(start), .rw(rw),
      .word_addr(word_addr), .wr_data(wr_data), .rd_data(rd_data),
      .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // divider model: toggle every 4 clk unless held
   initial forever begin
      @(negedge clk);
      if (!hold) begin
         div_cnt++;
         if (div_cnt == 4) begin
            div_cnt = 0;
            sclk_in = ~sclk_in;
         end
      end
   end

   // EEPROM slave and bus decoder: logs S=-1, P=-2, master NACK=-3, master ACK=-4, bytes
   initial forever begin
      @(negedge clk);
      c_scl = scl;
      c_sda = sda;
      if (p_scl && c_scl && p_sda && !c_sda) begin
         bus_log.push_back(-1);
         bitn = 0; byte_idx = 0; tx_mode = 1'b0; pending_tx = 1'b0; slave_low = 1'b0;
      end else if (p_scl && c_scl && !p_sda && c_sda) begin
         bus_log.push_back(-2);
         tx_mode = 1'b0; slave_low = 1'b0;
      end else if (!p_scl && c_scl) begin
         if (bitn < 8 && !tx_mode) shreg = {shreg[6:0], c_sda};
         else if (bitn == 8 && tx_mode) bus_log.push_back(c_sda ? -3 : -4);
         bitn++;
      end else if (p_scl && !c_scl) begin
         if (bitn == 8) begin
            if (tx_mode) slave_low = 1'b0;
            else begin
               bus_log.push_back(int'(shreg));
               if (byte_idx == 0) begin
                  ack_drv = (shreg[7:1] == 7'h50) && !slave_nack;
                  if (ack_drv && shreg[0]) pending_tx = 1'b1;
               end else if (byte_idx == 1) begin
                  ptr = shreg; ack_drv = 1'b1;
               end else begin
                  mem[ptr] = shreg; ack_drv = 1'b1;
               end
               byte_idx++;
               slave_low = ack_drv;
            end
         end else if (bitn == 9) begin
            bitn = 0;
            slave_low = 1'b0;
            if (pending_tx) begin
               pending_tx = 1'b0; tx_mode = 1'b1;
               txbyte = mem[ptr];
               slave_low = !txbyte[7];
            end else tx_mode = 1'b0;
         end else if (tx_mode && bitn >= 1 && bitn <= 7) begin
            slave_low = !txbyte[3'(7 - bitn)];
         end
      end
      p_scl = c_scl;
      p_sda = c_sda;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // transaction-level prediction: slots = START + 9 per byte + RESTART + STOP, 4 ticks each
   function automatic void predict(input logic p_rw, input logic [7:0] p_addr, input logic p_nack,
                                   output logic [7:0] p_rd, output logic p_err, output int p_ticks);
      int nbytes;
      p_err   = p_nack;
      p_rd    = (p_nack || !p_rw) ? rd_ref : mem_ref[p_addr];
      nbytes  = p_nack ? 1 : (p_rw ? 4 : 3);
      p_ticks = 4 * (1 + 9 * nbytes + ((p_rw && !p_nack) ? 1 : 0) + 1);
   endfunction

   task automatic run_txn(input logic t_rw, input logic [7:0] t_addr, input logic [7:0] t_data,
                          input logic t_nack, input int glitch, input logic [7:0] e_rd,
                          input logic e_err, input int e_ticks);
      int exp_log[$];
      int a_cyc;
      logic got;
      exp_log.push_back(-1);
      exp_log.push_back(32'hA0);
      if (!t_nack) begin
         exp_log.push_back(int'(t_addr));
         if (t_rw) begin
            exp_log.push_back(-1);
            exp_log.push_back(32'hA1);
            exp_log.push_back(-3);
         end else exp_log.push_back(int'(t_data));
      end
      exp_log.push_back(-2);

      slave_nack = t_nack;
      bus_log.delete();
      @(negedge clk);
      start = 1'b1; rw = t_rw; word_addr = t_addr; wr_data = t_data;
      @(negedge clk);
      start = 1'b0;
      a_cyc = cyc;
      check("busy_after_accept", busy, 1);
      check("ack_err_cleared", ack_err, 0);
      got = 1'b0;
      for (int k = 1; k <= 3000 && !got; k++) begin
         @(negedge clk);
         if (k == glitch) begin
            start = 1'b1; rw = ~t_rw; word_addr = t_addr ^ 8'hFF; wr_data = t_data ^ 8'hFF;
         end else if (k == glitch + 1) start = 1'b0;
         if (done) got = 1'b1;
      end
      check("done_seen", got, 1);
      if (got) begin
         if (e_ticks >= 0) check("ticks", (cyc - a_cyc + 7) / 8, e_ticks);
         check("busy_at_done", busy, 0);
         check("ack_err", ack_err, e_err);
         check("rd_data", rd_data, e_rd);
         check("log_len", bus_log.size(), exp_log.size());
         for (int i = 0; i < exp_log.size(); i++)
            check("log_item", (i < bus_log.size()) ? bus_log[i] : 32'hDEAD, exp_log[i]);
         @(negedge clk);
         check("done_one_clk", done, 0);
         if (!t_nack) begin
            if (t_rw) rd_ref = mem_ref[t_addr];
            else mem_ref[t_addr] = t_data;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic       found;
      int         bad;
      logic       s_scl, s_sda;
      logic [7:0] p_rd;
      logic       p_err;
      int         p_ticks;

      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'(i * 7 + 1);
         mem_ref[i] = 8'(i * 7 + 1);
      end
      mem[8'h34]     = 8'h5C;
      mem_ref[8'h34] = 8'h5C;

      vecs[0] = '{1'b0, 8'h12, 8'hA5, 1'b0, -5,  8'h00, 1'b0, 116};
      vecs[1] = '{1'b1, 8'h34, 8'h00, 1'b0, -5,  8'h5C, 1'b0, 156};
      vecs[2] = '{1'b0, 8'h56, 8'h77, 1'b1, -5,  8'h5C, 1'b1, 44};
      vecs[3] = '{1'b1, 8'h12, 8'h00, 1'b0, -5,  8'hA5, 1'b0, 156};
      vecs[4] = '{1'b0, 8'h9A, 8'h3C, 1'b0, 300, 8'hA5, 1'b0, 116};
      vecs[5] = '{1'b1, 8'h9A, 8'h00, 1'b0, -5,  8'h3C, 1'b0, 156};

      repeat (3) @(negedge clk);
      check("rst_scl", scl, 1);
      check("rst_sda", sda, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ack_err", ack_err, 0);
      check("rst_rd_data", rd_data, 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      for (int v = 0; v < 6; v++)
         run_txn(vecs[v].v_rw, vecs[v].v_addr, vecs[v].v_data, vecs[v].v_nack,
                 vecs[v].v_glitch, vecs[v].e_rd, vecs[v].e_err, vecs[v].e_ticks);

      // reset asserted during WADDR bit 3
      slave_nack = 1'b0;
      @(negedge clk);
      start = 1'b1; rw = 1'b0; word_addr = 8'h44; wr_data = 8'h99;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 3000 && !found; k++) begin
         @(negedge clk);
         if (byte_idx == 1 && bitn == 4) found = 1'b1;
      end
      check("reach_waddr_bit3", found, 1);
      check("busy_mid_txn", busy, 1);
      rst = 1'b0;
      #1;
      check("midrst_scl", scl, 1);
      check("midrst_sda", sda, 1);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      rd_ref = 8'h00;
      check("midrst_rd_data", rd_data, 0);
      repeat (4) @(negedge clk);
      run_txn(1'b0, 8'h44, 8'h99, 1'b0, -5, 8'h00, 1'b0, 116);

      // sclk_in held high for 500 clk in the middle of WADDR
      predict(1'b0, 8'h21, 1'b0, p_rd, p_err, p_ticks);
      fork
         run_txn(1'b0, 8'h21, 8'h5A, 1'b0, -5, p_rd, p_err, -1);
         begin
            repeat (20) @(negedge clk);
            found = 1'b0;
            for (int k = 0; k < 3000 && !found; k++) begin
               @(negedge clk);
               if (byte_idx == 1 && bitn == 4) found = 1'b1;
            end
            check("reach_freeze_point", found, 1);
            @(posedge sclk_in);
            hold = 1'b1;
            repeat (10) @(negedge clk);
            s_scl = scl;
            s_sda = sda;
            bad = 0;
            for (int k = 0; k < 490; k++) begin
               @(negedge clk);
               if (scl !== s_scl || sda !== s_sda || busy !== 1'b1 || done !== 1'b0) bad++;
            end
            check("freeze_stable", bad, 0);
            hold = 1'b0;
         end
      join

      for (int n = 0; n < 10; n++) begin
         logic       r_rw, r_nack;
         logic [7:0] r_addr, r_data;
         r_rw   = 1'($urandom_range(0, 1));
         r_addr = 8'($urandom);
         r_data = 8'($urandom);
         r_nack = ($urandom_range(0, 3) == 0);
         predict(r_rw, r_addr, r_nack, p_rd, p_err, p_ticks);
         run_txn(r_rw, r_addr, r_data, r_nack, -5, p_rd, p_err, p_ticks);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
